// File: rtl/circle_plot_if.sv
// Bundle of the command, pixel and circle-core signals around circle_plot.
// Signal names match the block's port list; direction is given by modport.
//
// Handshakes (valid/ready):
//   pixel port : drawing is valid, oe is ready. A pixel (x, y) is transferred on
//                a rising clk edge where drawing=1 and oe=1. While drawing=1 and
//                oe=0, x and y hold steady.
//   command    : start is sampled only while the block is idle. busy=1 means
//                further starts are ignored.
//   core port  : core_valid is valid, core_oe is ready. A (core_xa, core_ya)
//                pair is consumed on the edge where core_oe=1. core_start and
//                core_done are single-cycle pulses.
interface circle_plot_if #(
  parameter int CORDW = 16
);
  logic                    start;
  logic                    oe;
  logic signed [CORDW-1:0] x0;
  logic signed [CORDW-1:0] y0;
  logic signed [CORDW-1:0] r0;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic                    drawing;
  logic                    busy;
  logic                    done;
  logic                    core_start;
  logic signed [CORDW-1:0] core_r;
  logic                    core_oe;
  logic signed [CORDW-1:0] core_xa;
  logic signed [CORDW-1:0] core_ya;
  logic                    core_valid;
  logic                    core_done;

  // The plotter's own view.
  modport slave (
    input  start, oe, x0, y0, r0, core_xa, core_ya, core_valid, core_done,
    output x, y, drawing, busy, done, core_start, core_r, core_oe
  );

  // The view of whatever surrounds the plotter (decoder, framebuffer, core).
  modport master (
    output start, oe, x0, y0, r0, core_xa, core_ya, core_valid, core_done,
    input  x, y, drawing, busy, done, core_start, core_r, core_oe
  );
endinterface

// File: rtl/circle_plot.sv
// Circle plotter: starts the circle core, takes each octant distance pair it
// produces and emits the four mirrored absolute pixels, one per accepted oe.
module circle_plot #(
  parameter int CORDW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  circle_plot_if.slave        bus,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_PLOT    = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic signed [CORDW-1:0] x0_q, x0_d;
  logic signed [CORDW-1:0] y0_q, y0_d;
  logic signed [CORDW-1:0] r_q,  r_d;
  logic signed [CORDW-1:0] xa_q, xa_d;
  logic signed [CORDW-1:0] ya_q, ya_d;
  logic [1:0]              q_q,  q_d;

  // State and datapath registers; everything clears so x=y=0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      r_q     <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      r_q     <= r_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      q_q     <= q_d;
    end
  end

  // Next-state and register-load logic; a start while busy is simply not looked at.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    r_d     = r_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    q_d     = q_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          r_d     = bus.r0;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A pair takes precedence over done should both ever appear together.
        if (bus.core_valid) begin
          xa_d    = bus.core_xa;
          ya_d    = bus.core_ya;
          q_d     = 2'd0;
          state_d = S_PLOT;
        end else if (bus.core_done) begin
          state_d = S_DONE;
        end
      end
      S_PLOT: begin
        if (bus.oe) begin
          if (q_q == 2'd3) begin
            state_d = S_RELEASE;
          end else begin
            q_d = q_q + 2'd1;
          end
        end
      end
      S_RELEASE: begin
        state_d = S_WAIT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Mirror the latched octant distances into the four quadrants around the centre.
  always_comb begin
    bus.x = x0_q - xa_q;
    bus.y = y0_q + ya_q;
    unique case (q_q)
      2'd0: begin
        bus.x = x0_q - xa_q;
        bus.y = y0_q + ya_q;
      end
      2'd1: begin
        bus.x = x0_q - ya_q;
        bus.y = y0_q - xa_q;
      end
      2'd2: begin
        bus.x = x0_q + xa_q;
        bus.y = y0_q - ya_q;
      end
      default: begin
        bus.x = x0_q + ya_q;
        bus.y = y0_q + xa_q;
      end
    endcase
  end

  // Status and core handshake outputs are pure decodes of the registered state.
  assign bus.drawing    = (state_q == S_PLOT);
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.core_start = (state_q == S_START);
  assign bus.core_oe    = (state_q == S_RELEASE);
  assign bus.core_r     = r_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_circle_plot.sv
// Directed bench for circle_plot with a small behavioural circle-core stand-in
// that replays a fixed list of (xa, ya) pairs per circle.
module tb_circle_plot;
  localparam int CORDW = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_o;

  circle_plot_if #(.CORDW(CORDW)) bus ();

  circle_plot #(.CORDW(CORDW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] px_log [0:511];
  int pix_cnt  = 0;
  int done_cnt = 0;
  int cs_cnt   = 0;
  int coe_cnt  = 0;
  int nv_cnt   = 0;

  logic signed [CORDW-1:0] cx = '0;
  logic signed [CORDW-1:0] cy = '0;
  logic signed [CORDW-1:0] pxa [0:7];
  logic signed [CORDW-1:0] pya [0:7];
  int n_pairs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] px(input int xv, input int yv);
    return {16'(xv), 16'(yv)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- core stand-in ----------------
  logic s_start, s_oe;
  bit   c_busy = 1'b0;
  bit   c_next = 1'b0;
  int   c_idx  = 0;

  task automatic present(input int i);
    logic signed [CORDW-1:0] xa, ya;
    xa = pxa[i];
    ya = pya[i];
    bus.core_xa    = xa;
    bus.core_ya    = ya;
    bus.core_valid = 1'b1;
    nv_cnt++;
    exp_q.push_back({16'(cx - xa), 16'(cy + ya)});
    exp_q.push_back({16'(cx - ya), 16'(cy - xa)});
    exp_q.push_back({16'(cx + xa), 16'(cy - ya)});
    exp_q.push_back({16'(cx + ya), 16'(cy + xa)});
  endtask

  initial begin
    bus.core_valid = 1'b0;
    bus.core_done  = 1'b0;
    bus.core_xa    = '0;
    bus.core_ya    = '0;
    forever begin
      @(negedge clk);
      s_start = bus.core_start;
      s_oe    = bus.core_oe;
      tick();
      if (!rst_n) begin
        bus.core_valid = 1'b0;
        bus.core_done  = 1'b0;
        c_busy = 1'b0;
        c_next = 1'b0;
        c_idx  = 0;
        exp_q.delete();
      end else begin
        bus.core_done = 1'b0;
        if (s_start) begin
          c_busy = 1'b1;
          c_next = 1'b0;
          c_idx  = 0;
          present(0);
        end else if (c_busy && bus.core_valid && s_oe) begin
          bus.core_valid = 1'b0;
          c_idx++;
          c_next = 1'b1;
        end else if (c_busy && c_next) begin
          c_next = 1'b0;
          if (c_idx < n_pairs) begin
            present(c_idx);
          end else begin
            bus.core_done = 1'b1;
            c_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.drawing && bus.oe) begin
          px_log[pix_cnt % 512] = {bus.x, bus.y};
          if (exp_q.size() == 0) check("px_extra", 32'(exp_q.size()), 32'd1);
          else check("px", {bus.x, bus.y}, exp_q.pop_front());
          pix_cnt++;
        end
        if (bus.done)       done_cnt++;
        if (bus.core_start) cs_cnt++;
        if (bus.core_oe)    coe_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_circle(input int xv, input int yv, input int rv);
    cx = 16'(xv);
    cy = 16'(yv);
    bus.start = 1'b1;
    bus.x0 = 16'(xv);
    bus.y0 = 16'(yv);
    bus.r0 = 16'(rv);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_pix(input int base, input int n, input int budget);
    int k;
    k = 0;
    while (pix_cnt - base < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic load_r3();
    pxa[0] = -16'sd3; pya[0] = 16'sd0;
    pxa[1] = -16'sd3; pya[1] = 16'sd1;
    pxa[2] = -16'sd2; pya[2] = 16'sd2;
    n_pairs = 3;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int b_pix, b_done, b_cs, b_nv, b_coe;

  initial begin
    bus.start = 1'b0;
    bus.oe    = 1'b1;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.r0    = '0;
    rst_n     = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_drawing", 32'(bus.drawing), 32'd0);
    check("rst_done",    32'(bus.done), 32'd0);
    check("rst_cstart",  32'(bus.core_start), 32'd0);
    check("rst_coe",     32'(bus.core_oe), 32'd0);
    check("rst_xy",      {bus.x, bus.y}, 32'd0);
    check("rst_state",   32'(state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // test 1: r=3 at (10,10), oe held high
    load_r3();
    b_pix = pix_cnt; b_done = done_cnt; b_cs = cs_cnt; b_nv = nv_cnt;
    start_circle(10, 10, 3);
    check("t1_busy",     32'(bus.busy), 32'd1);
    check("t1_cstart",   32'(bus.core_start), 32'd1);
    check("t1_core_r",   32'(bus.core_r), 32'd3);
    tick();
    check("t1_cstart_1", 32'(bus.core_start), 32'd0);
    wait_done("t1_done", 200);
    check("t1_px0", px_log[b_pix + 0], px(13, 10));
    check("t1_px1", px_log[b_pix + 1], px(10, 13));
    check("t1_px2", px_log[b_pix + 2], px(7, 10));
    check("t1_px3", px_log[b_pix + 3], px(10, 7));
    check("t1_px4", px_log[b_pix + 4], px(13, 11));
    check("t1_npix",  32'(pix_cnt - b_pix), 32'd12);
    check("t1_4xval", 32'(pix_cnt - b_pix), 32'(4 * (nv_cnt - b_nv)));
    check("t1_ndone", 32'(done_cnt - b_done), 32'd1);
    check("t1_ncs",   32'(cs_cnt - b_cs), 32'd1);
    check("t1_busy_after", 32'(bus.busy), 32'd0);
    check("t1_left",  32'(exp_q.size()), 32'd0);

    // test 2: r=0 at (5,5)
    pxa[0] = 16'sd0; pya[0] = 16'sd0; n_pairs = 1;
    b_pix = pix_cnt; b_done = done_cnt; b_cs = cs_cnt;
    start_circle(5, 5, 0);
    wait_done("t2_done", 100);
    tick();
    check("t2_px0",   px_log[b_pix + 0], px(5, 5));
    check("t2_px3",   px_log[b_pix + 3], px(5, 5));
    check("t2_npix",  32'(pix_cnt - b_pix), 32'd4);
    check("t2_ndone", 32'(done_cnt - b_done), 32'd1);
    check("t2_ncs",   32'(cs_cnt - b_cs), 32'd1);

    // test 3: 20-cycle oe stall at q=2
    load_r3();
    b_pix = pix_cnt;
    start_circle(10, 10, 3);
    wait_pix(b_pix, 2, 100);
    bus.oe = 1'b0;
    b_coe = coe_cnt;
    check("t3_stall_px", {bus.x, bus.y}, px(7, 10));
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_hold", {bus.x, bus.y}, px(7, 10));
    end
    check("t3_state", 32'(state_o), 32'd3);
    check("t3_no_coe", 32'(coe_cnt - b_coe), 32'd0);
    bus.oe = 1'b1;
    wait_done("t3_done", 200);
    check("t3_npix", 32'(pix_cnt - b_pix), 32'd12);
    check("t3_left", 32'(exp_q.size()), 32'd0);

    // test 4: start held high every cycle while busy
    load_r3();
    b_pix = pix_cnt; b_cs = cs_cnt;
    start_circle(10, 10, 3);
    for (int k = 0; bus.busy && k < 300; k++) begin
      bus.start = 1'b1;
      bus.x0 = 16'($urandom_range(0, 1000));
      bus.y0 = 16'($urandom_range(0, 1000));
      bus.r0 = 16'($urandom_range(0, 50));
      tick();
    end
    bus.start = 1'b0;
    wait_done("t4_done", 50);
    tick();
    check("t4_px0",    px_log[b_pix + 0], px(13, 10));
    check("t4_core_r", 32'(bus.core_r), 32'd3);
    check("t4_npix",   32'(pix_cnt - b_pix), 32'd12);
    check("t4_ncs",    32'(cs_cnt - b_cs), 32'd1);
    check("t4_left",   32'(exp_q.size()), 32'd0);

    // test 5: reset during PLOT at q=2, then a fresh circle
    load_r3();
    b_pix = pix_cnt;
    start_circle(10, 10, 3);
    wait_pix(b_pix, 2, 100);
    bus.oe = 1'b0;
    tick();
    b_done = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_drawing", 32'(bus.drawing), 32'd0);
    check("t5_busy",    32'(bus.busy), 32'd0);
    check("t5_done",    32'(bus.done), 32'd0);
    check("t5_xy",      {bus.x, bus.y}, 32'd0);
    check("t5_state",   32'(state_o), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.oe = 1'b1;
    check("t5_no_done", 32'(done_cnt - b_done), 32'd0);
    tick();
    b_pix = pix_cnt;
    start_circle(-20, 40, 3);
    wait_done("t5_done_new", 200);
    check("t5_px0",  px_log[b_pix + 0], px(-17, 40));
    check("t5_npix", 32'(pix_cnt - b_pix), 32'd12);
    check("t5_left", 32'(exp_q.size()), 32'd0);

    // test 6: coordinate wrap at the positive edge
    pxa[0] = -16'sd2; pya[0] = 16'sd0; n_pairs = 1;
    b_pix = pix_cnt;
    start_circle(32767, 0, 2);
    wait_done("t6_done", 100);
    check("t6_q0_x", 32'(px_log[b_pix + 0][31:16]), 32'h8001);
    check("t6_q1",   px_log[b_pix + 1], px(32767, 2));
    check("t6_q3",   px_log[b_pix + 3], px(32767, -2));
    check("t6_npix", 32'(pix_cnt - b_pix), 32'd4);
    check("t6_left", 32'(exp_q.size()), 32'd0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
